// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: instruction width,
// opcode field layout and the NOP encoding.
package imem_responder_pkg;

    localparam int INST_W  = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_ALU    = 4'h3,
        OP_BRANCH = 4'hC
    } opcode_e;

    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    function automatic opcode_e get_opcode(input logic [INST_W-1:0] inst);
        return opcode_e'(inst[OPC_MSB:OPC_LSB]);
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch, response, flush and program-load signals between the fetch unit
// (master) and the instruction-memory responder (slave).
interface imem_responder_if #(parameter int AW = 16);
    import imem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [INST_W-1:0] resp_inst;
    logic [AW-1:0]     resp_addr;
    logic              flush;
    logic              ld_valid;
    logic              ld_ready;
    logic [AW-1:0]     ld_addr;
    logic [INST_W-1:0] ld_data;

    modport slave (
        input  req_valid, req_addr, resp_ready, flush, ld_valid, ld_addr, ld_data,
        output req_ready, resp_valid, resp_inst, resp_addr, ld_ready
    );

    modport master (
        output req_valid, req_addr, resp_ready, flush, ld_valid, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_inst, resp_addr, ld_ready
    );

endinterface

// File: rtl/imem_responder_resp_fifo.sv
// Small synchronous response FIFO with clear and occupancy count.
// The caller must not push when full unless it pops in the same cycle.
module imem_responder_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0]     occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: program RAM plus a response FIFO answering
// fetch requests in order, with branch-redirect flush and a program-load port.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int    AW         = 16,
    parameter int    FIFO_DEPTH = 2,
    parameter string INIT_FILE  = ""
) (
    input logic              clk,
    input logic              rst_n,
    imem_responder_if.slave  bus
);

    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = INST_W + AW;

    logic [INST_W-1:0]  ram [0:(2**AW)-1];
    logic [OCC_W-1:0]   occ;
    logic [ENTRY_W-1:0] head;
    logic               has_resp;
    logic               push;
    logic               pop;

    // Program-load port writes the RAM synchronously.
    always_ff @(posedge clk) begin
        if (bus.ld_valid) begin
            ram[bus.ld_addr] <= bus.ld_data;
        end
    end

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign has_resp      = (occ != '0);
    assign pop           = has_resp && bus.resp_ready;
    assign bus.req_ready = rst_n && !bus.ld_valid && !bus.flush &&
                           ((occ < OCC_W'(FIFO_DEPTH)) || pop);
    assign push          = bus.req_valid && bus.req_ready;

    imem_responder_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.flush),
        .push      (push),
        .push_data ({ram[bus.req_addr], bus.req_addr}),
        .pop       (pop),
        .pop_data  (head),
        .occ       (occ)
    );

    assign bus.resp_valid = has_resp;
    assign bus.resp_inst  = has_resp ? head[AW +: INST_W] : NOP_INST;
    assign bus.resp_addr  = has_resp ? head[AW-1:0] : '0;
    assign bus.ld_ready   = 1'b1;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios then random traffic, all
// checked against a queue-based model of the response stream.
module tb_imem_responder;

    localparam logic [15:0] W0 = 16'b0011001001100000;
    localparam logic [15:0] W1 = 16'b0011010010100000;
    localparam logic [15:0] W2 = 16'b0000001001100001;
    localparam logic [15:0] W3 = 16'h1357;
    localparam int DEPTH = 2;

    typedef struct {
        logic [15:0] inst;
        logic [15:0] addr;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   assert_count = 0;
    int   fail_count = 0;

    logic [15:0] ram_m [0:65535];
    resp_t       q[$];
    logic [15:0] got_addr[$];

    imem_responder_if #(.AW(16)) bus();

    imem_responder #(
        .AW         (16),
        .FIFO_DEPTH (DEPTH),
        .INIT_FILE  ("")
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_req_ready();
        return rst_n && !bus.ld_valid && !bus.flush &&
               ((q.size() < DEPTH) || ((q.size() > 0) && bus.resp_ready));
    endfunction

    task automatic set_inputs(input logic rv, input logic [15:0] ra, input logic rr,
                              input logic fl, input logic lv, input logic [15:0] la,
                              input logic [15:0] ldd);
        bus.req_valid  = rv;
        bus.req_addr   = ra;
        bus.resp_ready = rr;
        bus.flush      = fl;
        bus.ld_valid   = lv;
        bus.ld_addr    = la;
        bus.ld_data    = ldd;
    endtask

    task automatic check_output(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, exp_req_ready());
        chk({tag, "_resp_valid"}, bus.resp_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk({tag, "_resp_inst"}, bus.resp_inst, q[0].inst);
            chk({tag, "_resp_addr"}, bus.resp_addr, q[0].addr);
        end
        if (bus.resp_valid && bus.resp_ready) begin
            got_addr.push_back(bus.resp_addr);
        end
    endtask

    // Settle, check, advance the model across the coming edge, then step past it.
    task automatic apply_stimulus(input string tag);
        logic  acc;
        logic  deq;
        resp_t e;
        #1;
        check_output(tag);
        acc    = bus.req_valid && exp_req_ready();
        deq    = (q.size() > 0) && bus.resp_ready;
        e.inst = ram_m[bus.req_addr];
        e.addr = bus.req_addr;
        if (bus.ld_valid) ram_m[bus.ld_addr] = bus.ld_data;
        if (bus.flush) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_inputs(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_inst", bus.resp_inst, 16'h0000);
        chk("rst_resp_addr", bus.resp_addr, 16'h0000);
        rst_n = 1'b1;

        $display("[TB] load and back-to-back fetch");
        set_inputs(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'd0, W0); apply_stimulus("ld0");
        set_inputs(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'd1, W1); apply_stimulus("ld1");
        set_inputs(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'd2, W2); apply_stimulus("ld2");
        set_inputs(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'd3, W3); apply_stimulus("ld3");
        set_inputs(1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("f0");
        chk("t1_inst0", bus.resp_inst, W0);
        chk("t1_addr0", bus.resp_addr, 16'd0);
        set_inputs(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("f1");
        chk("t1_inst1", bus.resp_inst, W1);
        set_inputs(1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("f2");
        chk("t1_inst2", bus.resp_inst, W2);
        chk("t1_addr2", bus.resp_addr, 16'd2);
        set_inputs(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("drain1");
        chk("t1_empty", bus.resp_valid, 1'b0);

        $display("[TB] backpressure");
        got_addr.delete();
        set_inputs(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("bp0");
        set_inputs(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("bp1");
        set_inputs(1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
        #1 chk("t2_full_ready2", bus.req_ready, 1'b0);
        apply_stimulus("bp2");
        set_inputs(1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0);
        #1 chk("t2_full_ready3", bus.req_ready, 1'b0);
        apply_stimulus("bp3");
        chk("t2_hold_addr", bus.resp_addr, 16'd0);
        set_inputs(1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("bp4");
        set_inputs(1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("bp5");
        set_inputs(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("bp6");
        apply_stimulus("bp7");
        apply_stimulus("bp8");
        chk("t2_count", got_addr.size(), 4);
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            chk($sformatf("t2_order%0d", i), got_addr[i], i);
        end

        $display("[TB] load priority");
        set_inputs(1'b1, 16'd2, 1'b1, 1'b0, 1'b1, 16'd5, 16'hC502);
        #1 chk("t3_ld_blocks", bus.req_ready, 1'b0);
        apply_stimulus("ld5");
        set_inputs(1'b1, 16'd5, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("f5");
        chk("t3_inst", bus.resp_inst, 16'hC502);
        chk("t3_addr", bus.resp_addr, 16'd5);
        set_inputs(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("drain3");

        $display("[TB] flush");
        set_inputs(1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("fl0");
        set_inputs(1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("fl1");
        set_inputs(1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 16'd0, 16'h0); apply_stimulus("fl2");
        chk("t4_flushed", bus.resp_valid, 1'b0);
        set_inputs(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("fl3");
        chk("t4_inst", bus.resp_inst, W1);
        chk("t4_addr", bus.resp_addr, 16'd1);
        set_inputs(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("fl4");
        chk("t4_only_one", bus.resp_valid, 1'b0);

        $display("[TB] reset mid-stream");
        set_inputs(1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("rs0");
        set_inputs(1'b1, 16'd2, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("rs1");
        chk("t5_full_valid", bus.resp_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid_async", bus.resp_valid, 1'b0);
        chk("t5_ready_async", bus.req_ready, 1'b0);
        chk("t5_inst_async", bus.resp_inst, 16'h0000);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_inputs(1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("rs2");
        chk("t5_refetch", bus.resp_inst, W0);
        set_inputs(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("rs3");

        $display("[TB] top address");
        set_inputs(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h1234); apply_stimulus("ldtop");
        set_inputs(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("ftop");
        chk("t6_inst", bus.resp_inst, 16'h1234);
        chk("t6_addr", bus.resp_addr, 16'hFFFF);
        set_inputs(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0); apply_stimulus("drain6");

        $display("[TB] random traffic");
        for (int a = 0; a < 16; a++) begin
            set_inputs(1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 16'(a), 16'($urandom));
            apply_stimulus("rnd_pre");
        end
        for (int n = 0; n < 400; n++) begin
            set_inputs(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 15)),
                       ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 9) == 0), 16'($urandom_range(0, 15)),
                       16'($urandom));
            apply_stimulus("rnd");
        end
        set_inputs(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0);
        repeat (3) apply_stimulus("rnd_drain");
        chk("final_empty", bus.resp_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
